bc_poll_sequencer: RTL and testbench

- Bus-controller-side sequencer for the MKIO (GOST / MIL-STD-1553) channel.
- On a start pulse it polls every enabled remote terminal in turn with a "transmit" command word. For each terminal it checks the returned status word, forwards the data words that follow, and enforces a response timeout.
- It retries a failed exchange up to a programmable number of times.
- It sits between the channel TX encoder / RX decoder and the BC data store, and records sticky per-terminal error flags.

---
 rtl/bc_poll_sequencer_if.sv | 26 ++
 rtl/bc_poll_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_bc_poll_sequencer.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bc_poll_sequencer_if.sv
// Channel-side and data-store-side signals of the MKIO bus-controller poll sequencer.
// tx_ready, rx_valid and dat_valid are one-cycle strobes: the receiver must take the qualified word in that cycle; there is no back-pressure.
interface bc_poll_sequencer_if;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_done;
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        rx_valid;
  logic        p_error;
  logic [15:0] dat_out;
  logic [1:0]  dat_slot;
  logic [4:0]  dat_idx;
  logic        dat_valid;

  modport master (
    output tx_data, tx_cd, tx_ready, dat_out, dat_slot, dat_idx, dat_valid,
    input  tx_done, rx_data, rx_cd, rx_valid, p_error
  );

  modport slave (
    input  tx_data, tx_cd, tx_ready, dat_out, dat_slot, dat_idx, dat_valid,
    output tx_done, rx_data, rx_cd, rx_valid, p_error
  );
endinterface

// File: rtl/bc_poll_sequencer.sv
// Polls up to four remote terminals with transmit commands, checks status, forwards data,
// and retries failed exchanges, keeping sticky per-slot error flags.
module bc_poll_sequencer #(
  parameter logic [4:0] BASE_ADDR = 5'd1,
  parameter logic [4:0] SUBADDR   = 5'd1,
  parameter logic [7:0] TIMEOUT   = 8'd28,
  parameter logic [1:0] MAX_RETRY = 2'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 rt_mask,
  input  logic [4:0]                 wc_cfg,
  bc_poll_sequencer_if.master        bus,
  output logic [3:0]                 err_flags,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 dbg_state
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SELECT      = 4'd1,
    LOAD_CMD    = 4'd2,
    SEND_CMD    = 4'd3,
    WAIT_TX     = 4'd4,
    WAIT_STATUS = 4'd5,
    WAIT_DATA   = 4'd6,
    FAIL        = 4'd7,
    NEXT        = 4'd8,
    DONE        = 4'd9
  } state_t;

  state_t      r_state;
  logic [3:0]  r_mask;
  logic [4:0]  r_wc;
  logic [1:0]  r_slot;
  logic [5:0]  r_wcnt;
  logic [1:0]  r_retry;
  logic [7:0]  r_tmo;
  logic [15:0] r_tx_data;
  logic        r_tx_cd;
  logic        r_tx_ready;
  logic [15:0] r_dat_out;
  logic [1:0]  r_dat_slot;
  logic [4:0]  r_dat_idx;
  logic        r_dat_valid;
  logic [3:0]  r_err;
  logic        r_busy;
  logic        r_done;

  logic [4:0]  w_slot_addr;
  logic [5:0]  w_n_words;
  logic [5:0]  w_wcnt_next;
  logic [7:0]  w_tmo_next;
  logic        w_tmo_hit;
  logic        w_status_ok;
  logic        w_data_ok;

  // Address wraps modulo 32 by the 5-bit result width.
  assign w_slot_addr = BASE_ADDR + {3'b000, r_slot};
  assign w_n_words   = (r_wc == 5'd0) ? 6'd32 : {1'b0, r_wc};
  assign w_wcnt_next = r_wcnt + 6'd1;
  assign w_tmo_next  = (r_tmo >= TIMEOUT) ? TIMEOUT : r_tmo + 8'd1;
  assign w_tmo_hit   = (w_tmo_next == TIMEOUT);
  assign w_status_ok = bus.rx_cd && !bus.p_error &&
                       (bus.rx_data[15:11] == w_slot_addr) && !bus.rx_data[10];
  assign w_data_ok   = !bus.rx_cd && !bus.p_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mask      <= 4'd0;
      r_wc        <= 5'd0;
      r_slot      <= 2'd0;
      r_wcnt      <= 6'd0;
      r_retry     <= 2'd0;
      r_tmo       <= 8'd0;
      r_tx_data   <= 16'd0;
      r_tx_cd     <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_dat_out   <= 16'd0;
      r_dat_slot  <= 2'd0;
      r_dat_idx   <= 5'd0;
      r_dat_valid <= 1'b0;
      r_err       <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tx_ready  <= 1'b0;
      r_dat_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mask  <= rt_mask;
            r_wc    <= wc_cfg;
            r_err   <= r_err & ~rt_mask;
            r_slot  <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (!r_mask[r_slot]) begin
            r_state <= NEXT;
          end else begin
            r_retry <= 2'd0;
            r_state <= LOAD_CMD;
          end
        end
        LOAD_CMD: begin
          // tx_ready is registered here so it is high exactly while in SEND_CMD.
          r_tx_data  <= {w_slot_addr, 1'b1, SUBADDR, r_wc};
          r_tx_cd    <= 1'b1;
          r_tx_ready <= 1'b1;
          r_state    <= SEND_CMD;
        end
        SEND_CMD: r_state <= WAIT_TX;
        WAIT_TX: begin
          if (bus.tx_done) begin
            r_tmo   <= 8'd0;
            r_state <= WAIT_STATUS;
          end
        end
        WAIT_STATUS: begin
          // A word arriving on the timeout cycle wins over the timeout.
          if (bus.rx_valid) begin
            if (w_status_ok) begin
              r_wcnt  <= 6'd0;
              r_tmo   <= 8'd0;
              r_state <= WAIT_DATA;
            end else begin
              r_state <= FAIL;
            end
          end else begin
            r_tmo <= w_tmo_next;
            if (w_tmo_hit) r_state <= FAIL;
          end
        end
        WAIT_DATA: begin
          if (bus.rx_valid) begin
            if (w_data_ok) begin
              r_dat_valid <= 1'b1;
              r_dat_out   <= bus.rx_data;
              r_dat_slot  <= r_slot;
              r_dat_idx   <= r_wcnt[4:0];
              r_wcnt      <= w_wcnt_next;
              r_tmo       <= 8'd0;
              if (w_wcnt_next == w_n_words) r_state <= NEXT;
            end else begin
              r_state <= FAIL;
            end
          end else begin
            r_tmo <= w_tmo_next;
            if (w_tmo_hit) r_state <= FAIL;
          end
        end
        FAIL: begin
          if (r_retry < MAX_RETRY) begin
            r_retry <= r_retry + 2'd1;
            r_state <= LOAD_CMD;
          end else begin
            r_err[r_slot] <= 1'b1;
            r_state       <= NEXT;
          end
        end
        NEXT: begin
          if (r_slot == 2'd3) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_slot  <= r_slot + 2'd1;
            r_state <= SELECT;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_cd     = r_tx_cd;
  assign bus.tx_ready  = r_tx_ready;
  assign bus.dat_out   = r_dat_out;
  assign bus.dat_slot  = r_dat_slot;
  assign bus.dat_idx   = r_dat_idx;
  assign bus.dat_valid = r_dat_valid;
  assign err_flags     = r_err;
  assign busy          = r_busy;
  assign done          = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_bc_poll_sequencer.sv
// Directed bench for bc_poll_sequencer: acts as encoder/decoder and checks commands, data and flags.
module tb_bc_poll_sequencer;
  localparam logic [7:0] TIMEOUT = 8'd28;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rt_mask = 4'd0;
  logic [4:0] wc_cfg = 5'd0;
  logic [3:0] err_flags;
  logic       busy;
  logic       done;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int txr_cnt = 0;
  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];

  bc_poll_sequencer_if bus();

  bc_poll_sequencer #(
    .BASE_ADDR(5'd1), .SUBADDR(5'd1), .TIMEOUT(TIMEOUT), .MAX_RETRY(2'd1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rt_mask(rt_mask), .wc_cfg(wc_cfg),
    .bus(bus), .err_flags(err_flags), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dat_valid) got_q.push_back({bus.dat_slot, bus.dat_idx, bus.dat_out});
    if (bus.tx_ready) txr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    start = 1'b0;
    bus.tx_done = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_cd = 1'b0;
    bus.p_error = 1'b0;
    bus.rx_data = 16'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    txr_cnt = 0;
  endtask

  // Leaves the bench in cycle 1 (the cycle after the start edge).
  task automatic do_start(input logic [3:0] m, input logic [4:0] w);
    rt_mask = m;
    wc_cfg = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_txr(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      if (bus.tx_ready) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      if (done) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic send_done();
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic cd, input logic pe);
    bus.rx_data = d;
    bus.rx_cd = cd;
    bus.p_error = pe;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.p_error = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (bus.tx_data !== 16'd0 || bus.tx_cd !== 1'b0 || bus.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: got data=%h cd=%b rdy=%b, expected 0000 0 0", bus.tx_data, bus.tx_cd, bus.tx_ready);
    end
    checks++;
    if (bus.dat_valid !== 1'b0 || bus.dat_out !== 16'd0 || err_flags !== 4'd0) begin
      errors++;
      $display("FAIL reset_dat: got dv=%b dout=%h err=%b, expected 0 0000 0000", bus.dat_valid, bus.dat_out, err_flags);
    end
    checks++;
    if (dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    apply_reset();
    do_start(4'b0001, 5'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b expected 1", busy);
    end
    tick();
    checks++;
    if (bus.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL nominal_early_ready: cycle 2 tx_ready=%b expected 0", bus.tx_ready);
    end
    tick();
    checks++;
    if (bus.tx_ready !== 1'b1 || bus.tx_data !== 16'h0C23 || bus.tx_cd !== 1'b1) begin
      errors++;
      $display("FAIL nominal_cmd: cycle 3 rdy=%b data=%h cd=%b, expected 1 0c23 1", bus.tx_ready, bus.tx_data, bus.tx_cd);
    end
    send_done();
    send_word(16'h0800, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(16'hA001 + 16'(i), 1'b0, 1'b0);
      exp_q.push_back({2'd0, 5'(i), 16'hA001 + 16'(i)});
    end
    wait_done(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nominal_done: no done within 60 cycles, expected a pulse");
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL nominal_count: got %0d data words, expected %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL nominal_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (err_flags !== 4'd0 || txr_cnt != 1) begin
      errors++;
      $display("FAIL nominal_flags: got err=%b cmds=%0d, expected 0000 1", err_flags, txr_cnt);
    end
  endtask

  task automatic test_mask_zero();
    bit early;
    apply_reset();
    early = 1'b0;
    do_start(4'b0000, 5'd3);
    for (int c = 1; c < 9; c++) begin
      if (done) early = 1'b1;
      tick();
    end
    checks++;
    if (done !== 1'b1 || early) begin
      errors++;
      $display("FAIL mask0_done: cycle 9 done=%b early=%b, expected 1 0", done, early);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || txr_cnt != 0) begin
      errors++;
      $display("FAIL mask0_after: done=%b busy=%b cmds=%0d, expected 0 0 0", done, busy, txr_cnt);
    end
  endtask

  task automatic test_wc32();
    bit ok;
    int n;
    apply_reset();
    do_start(4'b0100, 5'd0);
    wait_txr(40, n, ok);
    checks++;
    if (!ok || bus.tx_data !== 16'h1C20) begin
      errors++;
      $display("FAIL wc32_cmd: seen=%b data=%h, expected 1 1c20", ok, bus.tx_data);
    end
    send_done();
    send_word(16'h1800, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      send_word(16'hB000 + 16'(i), 1'b0, 1'b0);
      exp_q.push_back({2'd2, 5'(i), 16'hB000 + 16'(i)});
    end
    wait_done(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wc32_done: no done within 40 cycles, expected a pulse");
    end
    checks++;
    if (got_q.size() != 32) begin
      errors++;
      $display("FAIL wc32_count: got %0d words expected 32", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wc32_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (err_flags !== 4'd0) begin
      errors++;
      $display("FAIL wc32_flags: got %b expected 0000", err_flags);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    apply_reset();
    do_start(4'b0011, 5'd1);
    wait_txr(40, n, ok);
    send_done();
    wait_txr(200, n, ok);
    checks++;
    if (!ok || n < int'(TIMEOUT) || n > int'(TIMEOUT) + 8 || bus.tx_data !== 16'h0C21) begin
      errors++;
      $display("FAIL timeout_retry: seen=%b gap=%0d data=%h, expected 1 gap %0d..%0d 0c21", ok, n, bus.tx_data, TIMEOUT, TIMEOUT + 8);
    end
    send_done();
    wait_txr(200, n, ok);
    checks++;
    if (!ok || n < int'(TIMEOUT) || bus.tx_data !== 16'h1421) begin
      errors++;
      $display("FAIL timeout_slot1: seen=%b gap=%0d data=%h, expected 1 gap>=%0d 1421", ok, n, bus.tx_data, TIMEOUT);
    end
    checks++;
    if (err_flags !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_flag_early: got %b expected 0001", err_flags);
    end
    send_done();
    send_word(16'h1000, 1'b1, 1'b0);
    send_word(16'hC000, 1'b0, 1'b0);
    wait_done(60, ok);
    checks++;
    if (!ok || err_flags !== 4'b0001 || txr_cnt != 3) begin
      errors++;
      $display("FAIL timeout_end: done=%b err=%b cmds=%0d, expected 1 0001 3", ok, err_flags, txr_cnt);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'd1, 5'd0, 16'hC000}) begin
      errors++;
      $display("FAIL timeout_data: got %0d words, expected 1 word from slot 1", got_q.size());
    end
  endtask

  task automatic test_bad_status();
    bit ok;
    int n;
    apply_reset();
    do_start(4'b0001, 5'd1);
    wait_txr(40, n, ok);
    send_done();
    send_word(16'h3800, 1'b1, 1'b0);
    wait_txr(40, n, ok);
    checks++;
    if (!ok || bus.tx_data !== 16'h0C21) begin
      errors++;
      $display("FAIL badaddr_retry: seen=%b data=%h, expected 1 0c21", ok, bus.tx_data);
    end
    send_done();
    send_word(16'h0C00, 1'b1, 1'b0);
    wait_done(60, ok);
    checks++;
    if (!ok || err_flags !== 4'b0001 || got_q.size() != 0 || txr_cnt != 2) begin
      errors++;
      $display("FAIL badstat_flag: done=%b err=%b words=%0d cmds=%0d, expected 1 0001 0 2", ok, err_flags, got_q.size(), txr_cnt);
    end
    tick();
    tick();
    got_q.delete();
    txr_cnt = 0;
    do_start(4'b0001, 5'd1);
    wait_txr(40, n, ok);
    send_done();
    send_word(16'h0C00, 1'b1, 1'b0);
    wait_txr(40, n, ok);
    send_done();
    send_word(16'h0800, 1'b1, 1'b0);
    send_word(16'hD001, 1'b0, 1'b0);
    wait_done(60, ok);
    checks++;
    if (!ok || err_flags !== 4'b0000 || txr_cnt != 2) begin
      errors++;
      $display("FAIL goodretry_flag: done=%b err=%b cmds=%0d, expected 1 0000 2", ok, err_flags, txr_cnt);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'd0, 5'd0, 16'hD001}) begin
      errors++;
      $display("FAIL goodretry_data: got %0d words, expected 1 word d001 idx 0", got_q.size());
    end
  endtask

  task automatic test_parity();
    bit ok;
    int n;
    apply_reset();
    do_start(4'b0001, 5'd3);
    wait_txr(40, n, ok);
    send_done();
    send_word(16'h0800, 1'b1, 1'b0);
    send_word(16'hE000, 1'b0, 1'b0);
    send_word(16'hE001, 1'b0, 1'b1);
    exp_q.push_back({2'd0, 5'd0, 16'hE000});
    wait_txr(40, n, ok);
    checks++;
    if (!ok || bus.tx_data !== 16'h0C23) begin
      errors++;
      $display("FAIL parity_retry: seen=%b data=%h, expected 1 0c23", ok, bus.tx_data);
    end
    send_done();
    send_word(16'h0800, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(16'hE010 + 16'(i), 1'b0, 1'b0);
      exp_q.push_back({2'd0, 5'(i), 16'hE010 + 16'(i)});
    end
    wait_done(60, ok);
    checks++;
    if (!ok || err_flags !== 4'd0) begin
      errors++;
      $display("FAIL parity_done: done=%b err=%b, expected 1 0000", ok, err_flags);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL parity_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    int n;
    apply_reset();
    do_start(4'b0001, 5'd1);
    wait_txr(40, n, ok);
    rt_mask = 4'b1111;
    wc_cfg = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    send_word(16'h0800, 1'b1, 1'b0);
    send_word(16'h5555, 1'b0, 1'b0);
    wait_done(60, ok);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (!ok || txr_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: done=%b cmds=%0d busy=%b, expected 1 1 0", ok, txr_cnt, busy);
    end
    checks++;
    if (got_q.size() != 1 || err_flags !== 4'd0) begin
      errors++;
      $display("FAIL busy_start_data: words=%0d err=%b, expected 1 0000", got_q.size(), err_flags);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n;
    apply_reset();
    do_start(4'b0001, 5'd3);
    wait_txr(40, n, ok);
    send_done();
    send_word(16'h0800, 1'b1, 1'b0);
    send_word(16'hF0F0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.dat_out !== 16'd0 || bus.tx_data !== 16'd0 || bus.tx_cd !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: busy=%b dout=%h txd=%h cd=%b, expected 0 0000 0000 0", busy, bus.dat_out, bus.tx_data, bus.tx_cd);
    end
    checks++;
    if (dbg_state !== 4'd0 || bus.dat_valid !== 1'b0 || err_flags !== 4'd0) begin
      errors++;
      $display("FAIL midreset_state: state=%0d dv=%b err=%b, expected 0 0 0000", dbg_state, bus.dat_valid, err_flags);
    end
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy || bus.tx_ready) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || got_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_after: activity=%b words=%0d, expected 0 1", seen, got_q.size());
    end
  endtask

  initial begin
    bus.tx_done = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_cd = 1'b0;
    bus.p_error = 1'b0;
    bus.rx_data = 16'd0;
    test_reset();
    test_nominal();
    test_mask_zero();
    test_wc32();
    test_timeout();
    test_bad_status();
    test_parity();
    test_busy_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
